// File: rtl/block_data_memory.sv
// Block-granular main data memory behind the data cache, with a fixed busywait latency per access.
// Optional read/write completion counters are enabled by defining DMEM_ACCESS_STATS_EN.
module block_data_memory #(
   parameter int ADDR_W  = 6,
   parameter int DATA_W  = 32,
   parameter int LATENCY = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              read,
   input  logic              write,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] writedata,
   output logic [DATA_W-1:0] readdata,
   output logic              busywait
`ifdef DMEM_ACCESS_STATS_EN
   ,
   output logic [15:0]       read_count,
   output logic [15:0]       write_count
`endif
);

   localparam int         DEPTH  = 2 ** ADDR_W;
   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t            state, state_next;
   logic [3:0]        cnt;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic              op_write_q;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              request;
   logic              done;

   assign request = read | write;
   assign done    = (state == BUSY) && (cnt == 4'd0);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // NOTE: the default assignment first keeps this block purely combinational (no latch).
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (request) state_next = BUSY;
         BUSY:    if (cnt == 4'd0) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busywait = (state == BUSY);
   end

   // NOTE: the array is cleared on reset, so it maps to flops rather than a RAM macro.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         readdata   <= '0;
         cnt        <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         op_write_q <= 1'b0;
      end else if (state == IDLE) begin
         if (request) begin
            addr_q     <= address;
            data_q     <= writedata;
            op_write_q <= write;       // read&write together behaves as a write
            cnt        <= LAT_M1;
         end
      end else if (cnt != 4'd0) begin
         cnt <= cnt - 4'd1;
      end else if (op_write_q) begin
         mem[addr_q] <= data_q;
      end else begin
         readdata <= mem[addr_q];
      end
   end

`ifdef DMEM_ACCESS_STATS_EN
   // Completion counters saturate instead of wrapping.
   always_ff @(posedge clock) begin
      if (reset) begin
         read_count  <= '0;
         write_count <= '0;
      end else if (done) begin
         if (op_write_q && write_count != 16'hFFFF)  write_count <= write_count + 16'd1;
         if (!op_write_q && read_count != 16'hFFFF)  read_count  <= read_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_block_data_memory.sv
// Randomized self-checking bench for block_data_memory against an array-based reference model.
// Counter checks are compiled in when DMEM_ACCESS_STATS_EN is defined.
module tb_block_data_memory;

   localparam int ADDR_W  = 6;
   localparam int DATA_W  = 32;
   localparam int LATENCY = 5;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              read = 1'b0;
   logic              write = 1'b0;
   logic [ADDR_W-1:0] address = '0;
   logic [DATA_W-1:0] writedata = '0;
   logic [DATA_W-1:0] readdata;
   logic              busywait;
`ifdef DMEM_ACCESS_STATS_EN
   logic [15:0]       read_count, write_count;
`endif

   block_data_memory #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(LATENCY)) dut (
      .clock      (clock),
      .reset      (reset),
      .read       (read),
      .write      (write),
      .address    (address),
      .writedata  (writedata),
      .readdata   (readdata),
      .busywait   (busywait)
`ifdef DMEM_ACCESS_STATS_EN
      ,
      .read_count (read_count),
      .write_count(write_count)
`endif
   );

   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;

   logic [DATA_W-1:0] ref_mem [2**ADDR_W];
   logic [DATA_W-1:0] ref_rd;
   int                ref_reads, ref_writes;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      foreach (ref_mem[i]) ref_mem[i] = '0;
      ref_rd     = '0;
      ref_reads  = 0;
      ref_writes = 0;
   endtask

   task automatic model_apply(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] d);
      if (wr) begin
         ref_mem[a] = d;
         ref_writes++;
      end else if (rd) begin
         ref_rd = ref_mem[a];
         ref_reads++;
      end
   endtask

   task automatic check_stats(input string tag);
`ifdef DMEM_ACCESS_STATS_EN
      check({tag, "_read_count"},  32'(read_count),  32'(ref_reads));
      check({tag, "_write_count"}, 32'(write_count), 32'(ref_writes));
`endif
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1; read = 1'b0; write = 1'b0;
      @(posedge clock);
      @(posedge clock);
      #1;
      reset = 1'b0;
      model_reset();
      check("reset_busywait", 32'(busywait), 32'd0);
      check("reset_readdata", readdata, 32'd0);
      check_stats("reset");
   endtask

   // One access; scramble perturbs address/data while busy, keep holds the request for a
   // back-to-back repeat that must be accepted one cycle after busywait falls.
   task automatic access(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input bit scramble, input bit keep);
      int cycles;
      @(negedge clock);
      read = rd; write = wr; address = a; writedata = d;
      for (int rep = 0; rep < (keep ? 2 : 1); rep++) begin
         @(posedge clock);
         #1;
         if (!keep || rep == 1) begin
            read = 1'b0; write = 1'b0;
         end
         cycles = 0;
         while (busywait && cycles < 40) begin
            if (scramble && !keep) begin
               address   = ADDR_W'($urandom);
               writedata = $urandom;
            end
            @(posedge clock);
            #1;
            cycles++;
         end
         check(keep ? "b2b_latency" : "latency", 32'(cycles), 32'(LATENCY));
         model_apply(rd, wr, a, d);
         check("readdata", readdata, ref_rd);
      end
   endtask

   initial begin
      do_reset();

      // Fresh memory reads as zero
      access(1'b1, 1'b0, 6'h05, 32'h0, 1'b0, 1'b0);

      access(1'b0, 1'b1, 6'h2A, 32'hDEADBEEF, 1'b0, 1'b0);
      access(1'b1, 1'b0, 6'h2A, 32'h0, 1'b0, 1'b0);

      // Inputs changing mid-access must not redirect the write
      access(1'b0, 1'b1, 6'h2A, 32'hA5A5_0F0F, 1'b1, 1'b0);
      access(1'b1, 1'b0, 6'h01, 32'h0, 1'b0, 1'b0);
      access(1'b1, 1'b0, 6'h2A, 32'h0, 1'b0, 1'b0);

      // read and write together behave as a write
      access(1'b1, 1'b1, 6'h10, 32'h12345678, 1'b0, 1'b0);
      access(1'b1, 1'b0, 6'h10, 32'h0, 1'b0, 1'b0);

      // Reset in the middle of a write drops it
      @(negedge clock);
      write = 1'b1; address = 6'h3F; writedata = 32'hCAFEF00D;
      @(posedge clock);
      #1;
      write = 1'b0;
      @(posedge clock);
      @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      model_reset();
      check("midreset_busywait", 32'(busywait), 32'd0);
      check("midreset_readdata", readdata, 32'd0);
      access(1'b1, 1'b0, 6'h3F, 32'h0, 1'b0, 1'b0);

      // Three reads and two writes for the counters
      do_reset();
      access(1'b0, 1'b1, 6'h07, 32'h0BAD_F00D, 1'b0, 1'b0);
      access(1'b1, 1'b0, 6'h07, 32'h0, 1'b0, 1'b0);
      access(1'b1, 1'b0, 6'h08, 32'h0, 1'b0, 1'b0);
      access(1'b0, 1'b1, 6'h08, 32'h7777_1234, 1'b0, 1'b0);
      access(1'b1, 1'b0, 6'h08, 32'h0, 1'b0, 1'b0);
      check_stats("stats");
      do_reset();

      access(1'b0, 1'b1, 6'h00, 32'h0000_0001, 1'b0, 1'b1);
      access(1'b1, 1'b0, 6'h00, 32'h0, 1'b0, 1'b1);

      for (int i = 0; i < 40; i++) begin
         logic              rd, wr;
         logic [ADDR_W-1:0] a;
         logic [DATA_W-1:0] d;
         bit                scr, kp;
         wr  = 1'($urandom);
         rd  = wr ? 1'($urandom) : 1'b1;
         a   = (i % 2 == 0) ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom);
         d   = $urandom;
         scr = 1'($urandom);
         kp  = ($urandom_range(0, 4) == 0);
         access(rd, wr, a, d, scr, kp);
      end
      check_stats("random");

      do_reset();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
